dispatch_ctrl: RTL
==================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have parameter: RS_DEPTH, 4, entries per reservation station (RS), i.e. the credit ceiling per FU; legal range 1..15.
REQ-002 SHALL have parameter: NUM_FU, 4, FU count; index 0=ALU, 1=LSU, 2=MUL, 3=BR.
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous active-high reset.
- inst_valid_i  in  1  renamed instruction present from decode.
- pc_i  in  32  instruction PC.
- alu_i / lsu_i / mul_i / br_i  in  1 each  FU select from decode.
- prs1_addr_i / prs2_addr_i / prd_addr_i  in  5 each  physical register tags.
- issue_i  in  NUM_FU  per-RS credit-return pulse: an RS entry was freed this cycle.
- flush_i  in  1  pipeline flush.
- stall_o  out  1  backpressure to fetch/decode.
- disp_valid_o  out  NUM_FU  one-hot dispatch strobe to the target RS.
- disp_pc_o  out  32  dispatched PC.
- disp_prs1_o / disp_prs2_o / disp_prd_o  out  5 each  dispatched tags.
- stall_cnt_o  out  32  stall-cycle counter (see Configuration).

Function
REQ-004 SHALL hold one instruction in a holding register with two states: EMPTY and HELD.
REQ-005 SHALL accept the input on a rising edge when inst_valid_i=1, stall_o=0 and flush_i=0; the state then becomes HELD.
REQ-006 SHALL resolve the target FU from the selects by fixed priority ALU>LSU>MUL>BR; an accepted instruction with no select set SHALL be dropped (state unchanged, no dispatch).
REQ-007 SHALL keep one credit counter per FU, each reset to RS_DEPTH.
REQ-008 SHALL drive disp_valid_o[t]=1 combinationally when state=HELD, the target is t, credit[t]>0 and flush_i=0; all other bits SHALL be 0.
REQ-009 SHALL drive the disp_* data outputs from the holding register at all times.
REQ-010 SHALL give a latency of exactly one cycle: an instruction accepted at edge N appears on disp_valid_o in cycle N+1 when a credit is available.
REQ-011 On a dispatch the holding register SHALL leave HELD, or reload in the same edge if a new instruction is accepted.
REQ-012 SHALL compute stall_o = HELD and not dispatching this cycle; back-to-back single-cycle dispatch SHALL sustain 1 instruction/cycle.
REQ-013 Dispatch SHALL decrement credit[t]; issue_i[t] SHALL increment it.
REQ-014 Simultaneous dispatch and issue on the same FU SHALL leave the credit unchanged.
REQ-015 An issue_i pulse with credit already at RS_DEPTH SHALL be ignored (saturate).
REQ-016 flush_i SHALL take effect at the next edge: state EMPTY, all credits restored to RS_DEPTH.
REQ-017 flush_i SHALL take priority over inst_valid_i and issue_i in the same cycle (both discarded).
REQ-018 Counter width SHALL be clog2(RS_DEPTH+1) bits; no wrap-around SHALL occur.

Reset
REQ-019 On reset_i=1 at an edge: state EMPTY, credits=RS_DEPTH, holding data=0, stall_cnt=0.
REQ-020 While reset is applied: stall_o=0, disp_valid_o=0.
REQ-021 reset_i SHALL override flush_i and all inputs in the same cycle.

Configuration
REQ-022 With macro DISPATCH_STALL_CNT_EN defined, stall_cnt_o SHALL count cycles with inst_valid_i=1 and stall_o=1.
REQ-023 With the macro defined, the counter SHALL saturate at 0xFFFFFFFF, clear only on reset, and be unaffected by flush_i.
REQ-024 Without DISPATCH_STALL_CNT_EN the port SHALL remain, stall_cnt_o SHALL be constant 0, and no counter flops SHALL be synthesized.

Structure
REQ-025 Shared package dispatch_pkg SHALL hold the FU index constants (FU_ALU=0, FU_LSU=1, FU_MUL=2, FU_BR=3), NUM_FU and the EMPTY/HELD state encoding.
REQ-026 The credit logic SHALL live in one sub-module, rs_credit_ctr (inc, dec, flush, count, nonzero), instantiated NUM_FU times.

Verification
REQ-027 Reset, then an ALU instruction pc=0x100, prd=5 at cycle 1 -> disp_valid_o=0001 in cycle 2 with disp_pc_o=0x100, disp_prd_o=5; credit[ALU]=3.
REQ-028 Five MUL instructions on consecutive cycles, no issue, RS_DEPTH=4 -> four dispatches in cycles 2..5; the 5th is HELD, stall_o=1 from cycle 6; an issue_i[2] pulse in cycle 8 -> dispatch in cycle 9.
REQ-029 credit[LSU]=0 with HELD LSU instruction, issue_i[1]=1 -> dispatch next cycle; then issue_i[1] and dispatch in the same cycle at credit=2 -> credit stays 2.
REQ-030 flush_i=1 together with inst_valid_i=1 while HELD and credits depleted -> next cycle EMPTY, no dispatch, all credits=4, input discarded.
REQ-031 Selects alu_i=lsu_i=1 -> dispatches to ALU only; all selects 0 -> no dispatch, stall_o stays 0.
REQ-032 With DISPATCH_STALL_CNT_EN: 3 stalled valid cycles -> stall_cnt_o=3; without the macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch stage: FU indices, FU count and holding-register states.
package dispatch_pkg;

  localparam int NUM_FU = 4;

  typedef logic [1:0] fu_idx_t;

  localparam fu_idx_t FU_ALU = 2'd0;
  localparam fu_idx_t FU_LSU = 2'd1;
  localparam fu_idx_t FU_MUL = 2'd2;
  localparam fu_idx_t FU_BR  = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Decode-to-dispatch bundle: renamed instruction in, per-RS dispatch strobe and payload out.
interface dispatch_ctrl_if #(
  parameter int NUM_FU = 4
);
  logic              inst_valid_i;
  logic [31:0]       pc_i;
  logic              alu_i;
  logic              lsu_i;
  logic              mul_i;
  logic              br_i;
  logic [4:0]        prs1_addr_i;
  logic [4:0]        prs2_addr_i;
  logic [4:0]        prd_addr_i;
  logic [NUM_FU-1:0] issue_i;
  logic              flush_i;
  logic              stall_o;
  logic [NUM_FU-1:0] disp_valid_o;
  logic [31:0]       disp_pc_o;
  logic [4:0]        disp_prs1_o;
  logic [4:0]        disp_prs2_o;
  logic [4:0]        disp_prd_o;
  logic [31:0]       stall_cnt_o;

  modport master (
    output inst_valid_i, pc_i, alu_i, lsu_i, mul_i, br_i,
           prs1_addr_i, prs2_addr_i, prd_addr_i, issue_i, flush_i,
    input  stall_o, disp_valid_o, disp_pc_o, disp_prs1_o, disp_prs2_o,
           disp_prd_o, stall_cnt_o
  );

  modport slave (
    input  inst_valid_i, pc_i, alu_i, lsu_i, mul_i, br_i,
           prs1_addr_i, prs2_addr_i, prd_addr_i, issue_i, flush_i,
    output stall_o, disp_valid_o, disp_pc_o, disp_prs1_o, disp_prs2_o,
           disp_prd_o, stall_cnt_o
  );
endinterface

// File: rtl/rs_credit_ctr.sv
// Free-entry credit counter for one reservation station; saturates at RS_DEPTH, never wraps.
module rs_credit_ctr #(
  parameter int RS_DEPTH = 4,
  parameter int CNT_W    = $clog2(RS_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RS_DEPTH);

  // Same-cycle inc and dec cancel; a return into a full RS is ignored.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush) begin
      count <= FULL;
    end else if (inc && !dec && count != FULL) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch holding register with per-FU credit flow control.
// Optional stall-cycle counter enabled by defining DISPATCH_STALL_CNT_EN.
module dispatch_ctrl #(
  parameter int RS_DEPTH = 4,
  parameter int NUM_FU   = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  dispatch_ctrl_if.slave bus
);
  import dispatch_pkg::*;

  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  disp_state_e       state_q;
  fu_idx_t           tgt_q;
  logic [31:0]       pc_q;
  logic [4:0]        prs1_q;
  logic [4:0]        prs2_q;
  logic [4:0]        prd_q;

  logic [NUM_FU-1:0] nonzero;
  logic [NUM_FU-1:0] disp_vld;
  logic [CNT_W-1:0]  credit [NUM_FU];
  logic              has_sel;
  fu_idx_t           sel_fu;
  logic              dispatching;
  logic              stall;
  logic              accept;

  always_comb begin
    has_sel = 1'b1;
    sel_fu  = FU_ALU;
    if (bus.alu_i)      sel_fu = FU_ALU;
    else if (bus.lsu_i) sel_fu = FU_LSU;
    else if (bus.mul_i) sel_fu = FU_MUL;
    else if (bus.br_i)  sel_fu = FU_BR;
    else                has_sel = 1'b0;
  end

  always_comb begin
    disp_vld = '0;
    if (state_q == HELD && nonzero[tgt_q] && !bus.flush_i && !reset_i)
      disp_vld[tgt_q] = 1'b1;
  end

  assign dispatching = |disp_vld;
  assign stall       = (state_q == HELD) && !dispatching && !reset_i;
  // Instructions with no FU select are consumed without entering the holding register.
  assign accept      = bus.inst_valid_i && !stall && !bus.flush_i && !reset_i && has_sel;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      tgt_q   <= FU_ALU;
      pc_q    <= '0;
      prs1_q  <= '0;
      prs2_q  <= '0;
      prd_q   <= '0;
    end else if (bus.flush_i) begin
      state_q <= EMPTY;
    end else if (accept) begin
      state_q <= HELD;
      tgt_q   <= sel_fu;
      pc_q    <= bus.pc_i;
      prs1_q  <= bus.prs1_addr_i;
      prs2_q  <= bus.prs2_addr_i;
      prd_q   <= bus.prd_addr_i;
    end else if (dispatching) begin
      state_q <= EMPTY;
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    rs_credit_ctr #(
      .RS_DEPTH (RS_DEPTH),
      .CNT_W    (CNT_W)
    ) u_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc     (bus.issue_i[f]),
      .dec     (disp_vld[f]),
      .flush   (bus.flush_i),
      .count   (credit[f]),
      .nonzero (nonzero[f])
    );

    always_ff @(posedge clk_i) begin
      if (!reset_i) assert (credit[f] <= CNT_W'(RS_DEPTH));
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      stall_cnt_q <= '0;
    else if (bus.inst_valid_i && stall && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = '0;
`endif

  assign bus.disp_valid_o = disp_vld;
  assign bus.stall_o      = stall;
  assign bus.disp_pc_o    = pc_q;
  assign bus.disp_prs1_o  = prs1_q;
  assign bus.disp_prs2_o  = prs2_q;
  assign bus.disp_prd_o   = prd_q;

endmodule
